// File: rtl/gsim_pkg.sv
// Shared types and sizes for the Gauss-Seidel result buffer.
// Q16.16 solution words, 16-word bursts, two ping-pong banks.
package gsim_pkg;

  localparam int DATA_W  = 32;
  localparam int VEC_LEN = 16;
  localparam int IDX_W   = 4;
  localparam int FRAC_W  = 16;
  localparam int SAT_W   = 16;
  localparam int NBANK   = 2;
  localparam int AW      = IDX_W + 1;

  typedef enum logic [1:0] {
    FREE,
    FILLING,
    FULL,
    DRAINING
  } bank_st_e;

endpackage

// File: rtl/gsim_rbuf_round.sv
// Q16.16 -> integer round-half-up, saturated to signed 16 b.
// Only instantiated when GSIM_RBUF_ROUND_EN is defined.
module gsim_rbuf_round
  import gsim_pkg::*;
(
  input  logic [DATA_W-1:0] d_i,
  output logic [DATA_W-1:0] q_o
);

  localparam int RW = DATA_W - FRAC_W + 1;
  localparam logic signed [RW-1:0] SMAX =
    RW'((1 << (SAT_W - 1)) - 1);
  localparam logic signed [RW-1:0] SMIN =
    RW'(-(1 << (SAT_W - 1)));

  logic signed [RW-1:0] r;
  logic signed [RW-1:0] rs;
  logic [SAT_W-1:0]     s16;
  logic                 unused_frac;

  assign unused_frac = ^d_i[FRAC_W-2:0];

  // floor(x/2^16) plus the half bit gives round-half-up
  always_comb begin
    r = $signed({d_i[DATA_W-1], d_i[DATA_W-1:FRAC_W]})
      + $signed({{(RW-1){1'b0}}, d_i[FRAC_W-1]});
    rs = r;
    if (r > SMAX) rs = SMAX;
    if (r < SMIN) rs = SMIN;
    s16 = rs[SAT_W-1:0];
    q_o = {{(DATA_W-SAT_W){s16[SAT_W-1]}}, s16};
  end

endmodule

// File: rtl/gsim_result_buffer.sv
// Ping-pong capture of solver bursts, drained over valid/ready.
// Optional output rounding: GSIM_RBUF_ROUND_EN.
module gsim_result_buffer
  import gsim_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [DATA_W-1:0] m_data,
  output logic [IDX_W-1:0]  m_index,
  output logic              m_last,
  output logic              busy,
  output logic              ovf_err,
  output logic              short_err,
  input  logic              clear_err
);

  bank_st_e st_q [NBANK];
  bank_st_e st_d [NBANK];

  logic [DATA_W-1:0] mem_q [NBANK*VEC_LEN];

  logic             wr_bank_q, wr_bank_d;
  logic             wr_tgt_q, wr_tgt_d;
  logic             drop_q, drop_d;
  logic             skip_q, skip_d;
  logic             older_q, older_d;
  logic [IDX_W-1:0] wr_cnt_q, wr_cnt_d;
  logic             rd_bank_q, rd_bank_d;

  logic              m_valid_q, m_valid_d;
  logic [DATA_W-1:0] m_data_q, m_data_d;
  logic [IDX_W-1:0]  m_index_q, m_index_d;
  logic              m_last_q, m_last_d;
  logic              ovf_q, ovf_d;
  logic              short_q, short_d;

  logic             hs, rel, load;
  logic             start, last_w;
  logic             cur_tgt, cur_drop;
  logic             fa, fb, pick;
  logic             ovf_new, short_new;
  logic             mem_we;
  logic [AW-1:0]    mem_wa;
  logic [AW-1:0]    rd_addr;
  logic             data_ld;
  logic [IDX_W-1:0] nidx;

  logic [DATA_W-1:0] rd_word;
  logic [DATA_W-1:0] out_word;

  assign rd_word = mem_q[rd_addr];

`ifdef GSIM_RBUF_ROUND_EN
  gsim_rbuf_round u_round (
    .d_i (rd_word),
    .q_o (out_word)
  );
`else
  assign out_word = rd_word;
`endif

  // Bank FSMs, write side, read side and sticky error flags
  always_comb begin
    st_d      = st_q;
    wr_bank_d = wr_bank_q;
    wr_tgt_d  = wr_tgt_q;
    drop_d    = drop_q;
    skip_d    = skip_q;
    older_d   = older_q;
    wr_cnt_d  = wr_cnt_q;
    rd_bank_d = rd_bank_q;
    m_valid_d = m_valid_q;
    m_index_d = m_index_q;
    m_last_d  = m_last_q;
    ovf_new   = 1'b0;
    short_new = 1'b0;
    mem_we    = 1'b0;
    data_ld   = 1'b0;
    rd_addr   = '0;
    nidx      = m_index_q + 1'b1;
    hs        = m_valid_q & m_ready;
    rel       = hs & m_last_q;
    load      = ~m_valid_q | m_ready;
    last_w    = (wr_cnt_q == IDX_W'(VEC_LEN - 1));
    start     = in_valid & ~skip_q & (wr_cnt_q == '0);
    cur_tgt   = wr_tgt_q;
    cur_drop  = drop_q;

    if (rel) st_d[rd_bank_q] = FREE;

    if (start) begin
      if (st_d[wr_bank_q] == FREE) begin
        cur_tgt  = wr_bank_q;
        cur_drop = 1'b0;
      end else if (st_d[~wr_bank_q] == FREE) begin
        cur_tgt  = ~wr_bank_q;
        cur_drop = 1'b0;
      end else begin
        cur_tgt  = wr_bank_q;
        cur_drop = 1'b1;
      end
    end
    mem_wa = {cur_tgt, wr_cnt_q};

    if (skip_q) begin
      if (!in_valid) skip_d = 1'b0;
    end else if (in_valid) begin
      wr_tgt_d = cur_tgt;
      drop_d   = cur_drop;
      wr_cnt_d = wr_cnt_q + 1'b1;
      if (start && cur_drop) ovf_new = 1'b1;
      if (!cur_drop) begin
        mem_we = 1'b1;
        st_d[cur_tgt] = last_w ? FULL : FILLING;
        if (last_w) begin
          wr_bank_d = ~cur_tgt;
          if (st_q[~cur_tgt] != FULL) older_d = cur_tgt;
        end
      end
    end else if (wr_cnt_q != '0) begin
      wr_cnt_d  = '0;
      short_new = 1'b1;
      if (!drop_q) st_d[wr_tgt_q] = FREE;
    end

    fa   = (st_d[0] == FULL);
    fb   = (st_d[1] == FULL);
    pick = (fa && fb) ? older_q : fb;

    if (load) begin
      if (m_valid_q && !m_last_q) begin
        rd_addr   = {rd_bank_q, nidx};
        data_ld   = 1'b1;
        m_index_d = nidx;
        m_last_d  = (nidx == IDX_W'(VEC_LEN - 1));
      end else if (fa || fb) begin
        rd_addr    = {pick, {IDX_W{1'b0}}};
        data_ld    = 1'b1;
        m_valid_d  = 1'b1;
        rd_bank_d  = pick;
        m_index_d  = '0;
        m_last_d   = 1'b0;
        st_d[pick] = DRAINING;
      end else begin
        m_valid_d = 1'b0;
        m_last_d  = 1'b0;
      end
    end

    ovf_d   = (ovf_q & ~clear_err) | ovf_new;
    short_d = (short_q & ~clear_err) | short_new;
  end

  // Output data register loads only on an advance
  always_comb begin
    m_data_d = m_data_q;
    if (data_ld) m_data_d = out_word;
  end

  // Control and output state
  always_ff @(posedge clk) begin
    if (reset) begin
      st_q[0]   <= FREE;
      st_q[1]   <= FREE;
      wr_bank_q <= 1'b0;
      wr_tgt_q  <= 1'b0;
      drop_q    <= 1'b0;
      skip_q    <= in_valid;
      older_q   <= 1'b0;
      wr_cnt_q  <= '0;
      rd_bank_q <= 1'b0;
      m_valid_q <= 1'b0;
      m_data_q  <= '0;
      m_index_q <= '0;
      m_last_q  <= 1'b0;
      ovf_q     <= 1'b0;
      short_q   <= 1'b0;
    end else begin
      st_q      <= st_d;
      wr_bank_q <= wr_bank_d;
      wr_tgt_q  <= wr_tgt_d;
      drop_q    <= drop_d;
      skip_q    <= skip_d;
      older_q   <= older_d;
      wr_cnt_q  <= wr_cnt_d;
      rd_bank_q <= rd_bank_d;
      m_valid_q <= m_valid_d;
      m_data_q  <= m_data_d;
      m_index_q <= m_index_d;
      m_last_q  <= m_last_d;
      ovf_q     <= ovf_d;
      short_q   <= short_d;
    end
  end

  // Bank storage, no reset needed
  always_ff @(posedge clk) begin
    if (mem_we) mem_q[mem_wa] <= in_data;
  end

  assign m_valid   = m_valid_q;
  assign m_data    = m_data_q;
  assign m_index   = m_index_q;
  assign m_last    = m_last_q;
  assign busy      = (st_q[0] != FREE) | (st_q[1] != FREE);
  assign ovf_err   = ovf_q;
  assign short_err = short_q;

endmodule
